press_classifier: RTL and testbench



---
 rtl/press_classifier.sv | 106 ++++++++++
 tb/tb_press_classifier.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// press_classifier: per-channel sync, short/long press classify, run toggle and activity counter; in clk rst press clr, out short_p long_p toggle count; define PRESS_CLASSIFIER_DEBOUNCE_EN for a DB_CYC debounce stage
module press_classifier #(
  parameter int CH       = 4,
  parameter int CNT_W    = 4,
  parameter int HOLD_W   = 16,
  parameter int LONG_CYC = 1000,
  parameter int DB_CYC   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       press,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       short_p,
  output logic [CH-1:0]       long_p,
  output logic [CH-1:0]       toggle,
  output logic [CH*CNT_W-1:0] count
);
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  if (LONG_CYC < 2 || DB_CYC < 1 || (LONG_CYC >> HOLD_W) != 0) begin : g_bad
    $error("press_classifier: illegal parameters");
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic s1, s2, ps, prev, sp, lp, tog, sp_n, lp_n, tog_n;
    logic [HOLD_W-1:0] hold, hold_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    state_t st, st_n;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= press[i];
        s2 <= s1;
      end
    end
`ifdef PRESS_CLASSIFIER_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CYC + 1);
    logic [DW-1:0] db;
    logic ps_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        db   <= '0;
        ps_q <= 1'b0;
      end else if (s2 == ps_q) begin
        db <= '0;
      end else if (db == DW'(DB_CYC - 1)) begin
        db   <= '0;
        ps_q <= s2;
      end else begin
        db <= db + 1'b1;
      end
    end
    assign ps = ps_q;
`else
    assign ps = s2;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        st   <= IDLE;
        prev <= 1'b0;
        hold <= '0;
        sp   <= 1'b0;
        lp   <= 1'b0;
        tog  <= 1'b0;
        cnt  <= '0;
      end else begin
        st   <= st_n;
        prev <= ps;
        hold <= hold_n;
        sp   <= sp_n;
        lp   <= lp_n;
        tog  <= tog_n;
        cnt  <= cnt_n;
      end
    end
    always_comb begin
      st_n   = st;
      hold_n = hold;
      sp_n   = 1'b0;
      lp_n   = 1'b0;
      case (st)
        IDLE: if (ps & ~prev) begin
          st_n   = HELD;
          hold_n = HOLD_W'(1);
        end
        HELD: if (!ps) begin
          sp_n = 1'b1;
          st_n = IDLE;
        end else if (hold == HOLD_W'(LONG_CYC - 1)) begin
          lp_n = 1'b1;
          st_n = LONG;
        end else begin
          hold_n = hold + 1'b1;
        end
        LONG: st_n = ps ? LONG : IDLE;
        default: st_n = IDLE;
      endcase
      tog_n = (clr[i] | lp_n) ? 1'b0 : sp_n ? ~tog : tog;
      cnt_n = (clr[i] | lp_n) ? '0 : cnt + CNT_W'(tog);
    end
    assign short_p[i]                 = sp;
    assign long_p[i]                  = lp;
    assign toggle[i]                  = tog;
    assign count[i*CNT_W +: CNT_W]    = cnt;
  end
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed checks of short/long classification, toggle, counter, clr and reset on press_classifier
module tb_press_classifier;
  localparam int CH = 4;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] press = '0;
  logic [CH-1:0] clr = '0;
  logic [CH-1:0] short_p, long_p, toggle;
  logic [CH*CNT_W-1:0] count;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int sp_n[CH], sp_at[CH], sp_tog[CH], sp_cnt[CH];
  int lp_n[CH], lp_at[CH], lp_tog[CH], lp_cnt[CH];
  int c0, r;

  press_classifier #(.CH(CH), .CNT_W(CNT_W), .HOLD_W(16), .LONG_CYC(8), .DB_CYC(8)) dut (
    .clk(clk), .rst(rst), .press(press), .clr(clr),
    .short_p(short_p), .long_p(long_p), .toggle(toggle), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(count[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_rec;
    for (int c = 0; c < CH; c++) begin
      sp_n[c] = 0; sp_at[c] = -1; sp_tog[c] = -1; sp_cnt[c] = -1;
      lp_n[c] = 0; lp_at[c] = -1; lp_tog[c] = -1; lp_cnt[c] = -1;
    end
  endtask

  task automatic run(input int n);
    for (int s = 0; s < n; s++) begin
      step();
      for (int c = 0; c < CH; c++) begin
        if (short_p[c]) begin
          sp_n[c]++; sp_at[c] = cyc; sp_tog[c] = int'(toggle[c]); sp_cnt[c] = cnt_of(c);
        end
        if (long_p[c]) begin
          lp_n[c]++; lp_at[c] = cyc; lp_tog[c] = int'(toggle[c]); lp_cnt[c] = cnt_of(c);
        end
      end
    end
  endtask

  initial begin
    clear_rec();
    repeat (3) step();
    rst = 1'b0;
    chk("rst short_p", int'(short_p), 0);
    chk("rst long_p", int'(long_p), 0);
    chk("rst toggle", int'(toggle), 0);
    chk("rst count", int'(count), 0);
    run(20);
    chk("idle count", int'(count), 0);
    chk("idle pulses", sp_n[0] + sp_n[1] + sp_n[2] + sp_n[3] + lp_n[0] + lp_n[1] + lp_n[2] + lp_n[3], 0);

    // short press on ch0: held 4 cycles, short_p 3 edges after the last high edge
    clear_rec();
    c0 = cyc;
    press[0] = 1'b1;
    run(4);
    press[0] = 1'b0;
    run(4);
    chk("s0 short count", sp_n[0], 1);
    chk("s0 short edge", sp_at[0], c0 + 7);
    chk("s0 no long", lp_n[0], 0);
    chk("s0 toggle at pulse", sp_tog[0], 1);
    chk("s0 count at pulse", sp_cnt[0], 0);
    chk("s0 count 1", cnt_of(0), 1);
    run(2);
    chk("s0 count 3", cnt_of(0), 3);
    run(12);
    chk("s0 count 15", cnt_of(0), 15);
    run(1);
    chk("s0 count wrap", cnt_of(0), 0);
    chk("s0 single pulse", sp_n[0], 1);

    // ch1: set toggle and count 5, then long press
    clear_rec();
    press[1] = 1'b1;
    run(2);
    press[1] = 1'b0;
    run(8);
    chk("l1 setup toggle", int'(toggle[1]), 1);
    chk("l1 setup count", cnt_of(1), 5);
    clear_rec();
    c0 = cyc;
    press[1] = 1'b1;
    run(20);
    press[1] = 1'b0;
    run(6);
    chk("l1 long count", lp_n[1], 1);
    chk("l1 long edge", lp_at[1], c0 + 10);
    chk("l1 toggle at long", lp_tog[1], 0);
    chk("l1 count at long", lp_cnt[1], 0);
    chk("l1 no short", sp_n[1], 0);
    chk("l1 toggle after", int'(toggle[1]), 0);

    // clr alone on ch0
    clr[0] = 1'b1;
    run(1);
    clr[0] = 1'b0;
    chk("clr0 toggle", int'(toggle[0]), 0);
    chk("clr0 count", cnt_of(0), 0);

    // simultaneous short presses on ch0/ch2 with clr[2] on the pulse edge
    clear_rec();
    c0 = cyc;
    press = 4'b0101;
    run(3);
    press = '0;
    run(2);
    clr[2] = 1'b1;
    run(1);
    clr[2] = 1'b0;
    run(3);
    chk("m0 short", sp_n[0], 1);
    chk("m2 short", sp_n[2], 1);
    chk("m0 edge", sp_at[0], c0 + 6);
    chk("m2 edge", sp_at[2], c0 + 6);
    chk("m0 toggle", sp_tog[0], 1);
    chk("m2 toggle clr", sp_tog[2], 0);
    chk("m2 count clr", sp_cnt[2], 0);
    chk("m2 toggle after", int'(toggle[2]), 0);
    chk("m other short", sp_n[1] + sp_n[3], 0);
    chk("m no long", lp_n[0] + lp_n[2], 0);

    // ch3 long hold, reset mid-hold, fresh rise after reset
    clear_rec();
    press[3] = 1'b1;
    run(12);
    chk("r3 first long", lp_n[3], 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    r = cyc;
    chk("r3 rst short_p", int'(short_p), 0);
    chk("r3 rst long_p", int'(long_p), 0);
    chk("r3 rst toggle", int'(toggle), 0);
    chk("r3 rst count", int'(count), 0);
    clear_rec();
    run(12);
    chk("r3 relong count", lp_n[3], 1);
    chk("r3 relong edge", lp_at[3], r + 10);
    press[3] = 1'b0;
    clear_rec();
    run(5);
    chk("r3 release quiet", sp_n[3] + lp_n[3], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
